// File: rtl/led_data_feeder.sv
// Pixel-pair packer, 4-deep word FIFO and DAI/DEN serialiser feeding the
// LED controller's DCK serial-load port (32 bits per word, gap separated).
module led_data_feeder #(
    parameter int unsigned WORD_GAP  = 1,
    parameter int unsigned FRAME_GAP = 4
) (
    input  logic       DCK,
    input  logic       rst_n,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    input  logic       pix_sof,
    output logic       pix_ready,
    output logic       DAI,
    output logic       DEN,
    output logic       frame_done,
    output logic       sof_err
);

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned WORD_W     = 2 * PIX_W;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned IDX_W      = 9;
    localparam int unsigned BIT_W      = 5;
    localparam int unsigned GAP_W      = 4;
    localparam int unsigned WCNT_W     = 8;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(31);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(255);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    pix_idx_q, pix_idx_d;
    logic [PIX_W-1:0]    pack_lo_q, pack_lo_d;
    logic [WORD_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WORD_W-1:0]   shift_word_q, shift_word_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic                pix_ready_q, pix_ready_d;
    logic                dai_q, dai_d;
    logic                den_q, den_d;
    logic                frame_done_q, frame_done_d;
    logic                sof_err_q, sof_err_d;

    logic                accept;
    logic                push;
    logic                pop;
    logic [WORD_W-1:0]   push_word;
    logic [WORD_W-1:0]   fifo_head;
    logic [BIT_W-1:0]    next_bit;

    assign pix_ready  = pix_ready_q;
    assign DAI        = dai_q;
    assign DEN        = den_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

    // Bit k of a word: bytes are repeated, so k[3] is ignored and k[4] picks the byte.
    function automatic logic serial_bit(input logic [WORD_W-1:0] word,
                                        input logic [BIT_W-1:0]  k);
        logic [3:0] sel;
        sel = {k[4], k[2:0]};
        return word[sel];
    endfunction

    assign accept    = pix_valid && pix_ready_q;
    assign push      = accept && pix_idx_q[0];
    assign pop       = (state_q == ST_IDLE) && (count_q != '0);
    assign push_word = {pix_data, pack_lo_q};
    assign fifo_head = fifo_mem_q[rd_ptr_q];
    assign next_bit  = bit_cnt_q + BIT_W'(1);

    // Input side: packing, FIFO pointers/count, sof checking.
    always_comb begin
        pix_idx_d   = pix_idx_q;
        pack_lo_d   = pack_lo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        sof_err_d   = sof_err_q;

        if (accept) begin
            pix_idx_d = pix_idx_q + IDX_W'(1);
            if (!pix_idx_q[0]) begin
                pack_lo_d = pix_data;
            end
            if (pix_sof && (pix_idx_q != '0)) begin
                sof_err_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        pix_ready_d = (count_d != FULL_CNT);
    end

    // Serialiser next-state and registered DAI/DEN/frame_done.
    always_comb begin
        state_d      = state_q;
        shift_word_d = shift_word_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        word_cnt_d   = word_cnt_q;
        dai_d        = 1'b0;
        den_d        = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    shift_word_d = fifo_head;
                    bit_cnt_d    = '0;
                    dai_d        = fifo_head[0];
                    den_d        = 1'b1;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bit_cnt_q == LAST_BIT) begin
                    gap_cnt_d    = (word_cnt_q == LAST_WORD) ? GAP_W'(FRAME_GAP)
                                                             : GAP_W'(WORD_GAP);
                    frame_done_d = (word_cnt_q == LAST_WORD);
                    word_cnt_d   = word_cnt_q + WCNT_W'(1);
                    state_d      = ST_GAP;
                end else begin
                    bit_cnt_d = next_bit;
                    dai_d     = serial_bit(shift_word_q, next_bit);
                    den_d     = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage needs no reset; only entries below count are ever read.
    always_ff @(posedge DCK) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge DCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pix_idx_q    <= '0;
            pack_lo_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            shift_word_q <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            word_cnt_q   <= '0;
            pix_ready_q  <= 1'b1;
            dai_q        <= 1'b0;
            den_q        <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_idx_q    <= pix_idx_d;
            pack_lo_q    <= pack_lo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            shift_word_q <= shift_word_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            word_cnt_q   <= word_cnt_d;
            pix_ready_q  <= pix_ready_d;
            dai_q        <= dai_d;
            den_q        <= den_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

endmodule
